dual_port_memory_bank_wide: RTL and testbench
=============================================

Name: dual_port_memory_bank_wide

Overview:
Next-generation simple dual-port RAM bank: one write port (A) and one read port (B), parametrised word width with per-byte write strobes.
- Synchronous read with configurable latency and a valid flag.
- Write-first forwarding on same-address collision.
- Hardware clear sequencer that zeroes the array after reset.
- Serves as the shared storage primitive for instruction/data memory and scratch buffers in the RV32E system.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DATA_DEPTH, 4096, number of words; must be a power of two, at least 2.
READ_LATENCY, 1, cycles from read request to data; legal values are 1 or 2.
CLEAR_ON_RESET, 1, 1 = run the zeroing sequence after reset; 0 = array content undefined and the bank is ready immediately.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
busy  out  1  high while the clear sequence runs; both ports are ignored while high.
we  in  1  write enable, port A.
wstrb  in  DATA_WIDTH/8  byte-lane write strobes; bit i enables byte i.
addr_a  in  $clog2(DATA_DEPTH)  write address.
write_data  in  DATA_WIDTH  write data.
re  in  1  read request, port B.
addr_b  in  $clog2(DATA_DEPTH)  read address.
read_data  out  DATA_WIDTH  read data; holds its last value when read_valid is low.
read_valid  out  1  read_data valid this cycle (single-cycle pulse per request).

Behaviour:
Reset (rst_n low, asynchronous):
- busy=1 if CLEAR_ON_RESET, else 0.
- read_data=0, read_valid=0, clear counter=0, read pipeline flushed.
- The array itself is not reset.

Clear FSM (states CLEAR, READY):
- After rst_n deasserts, CLEAR writes all-zero to one word per cycle, address 0 upward.
- After writing address DATA_DEPTH-1 it enters READY the next cycle, and busy drops at that edge.
- Clear takes exactly DATA_DEPTH cycles.
- we/re are ignored in CLEAR: writes are dropped and no read_valid is produced.
- rst_n asserted mid-clear restarts the clear from address 0.
- With CLEAR_ON_RESET=0 the FSM resets directly into READY.

Write:
- In READY, with we=1, each byte i with wstrb[i]=1 is updated at addr_a on the clock edge.
- Bytes with wstrb[i]=0 are unchanged.
- we=1 with wstrb=0 is a no-op.

Read:
- In READY, with re=1, the word at addr_b is sampled on the edge.
- READY_LATENCY=1: read_data/read_valid are updated at that edge.
- READ_LATENCY=2: one further register stage.
- Back-to-back reads sustain one per cycle.
- read_valid is high for exactly one cycle per accepted re.

Collision (write-first):
- Condition: we=1 and re=1 in the same cycle with addr_a==addr_b.
- Returned data is the merged word: new bytes where wstrb=1, old stored bytes elsewhere.

Addresses: out-of-range values cannot occur, since the width is exact.

Optional Feature:
Macro: DUAL_PORT_MEMORY_BANK_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written alongside its byte.
  - Extra output parity_err (1 bit) is aligned with read_valid.
  - parity_err is high if any lane of the returned word fails its check; it resets to 0.
  - The clear sequence writes correct parity (0) for zero data.
  - Forwarded collision data carries freshly computed parity.
- Undefined: no parity storage and no parity_err port.

Decomposition:
Shared package mem_pkg:
- read_latency_e (LAT1, LAT2);
- clear state enum (CLEAR, READY);
- function byte_merge(old, new, strb) for the collision path;
- function even_parity.

Natural sub-module: mem_clear_seq, containing the counter, FSM and busy logic, which drives the internal write mux.
The array and the read pipeline stay in the top module.

Test Plan:
1. Reset, DATA_DEPTH=16, CLEAR_ON_RESET=1 -> busy high for exactly 16 cycles; then reading all 16 addresses returns 0x00000000 with read_valid one cycle after each re.
2. Write 0xDEADBEEF to addr 5 with wstrb=4'b1111, then write 0x000000AA with wstrb=4'b0001, then read addr 5 -> 0xDEADBEAA.
3. Same cycle: we=1, wstrb=4'b0110, addr_a=addr_b=9, write_data=0x11223344, old word 0xAABBCCDD, re=1 -> read_data=0xAA2233DD; a subsequent read also returns 0xAA2233DD.
4. READ_LATENCY=2, re on addrs 1,2,3 in consecutive cycles -> read_valid high on cycles +2, +3, +4 with the matching data; read_data holds after the burst.
5. Assert rst_n low at cycle 8 of the clear, with we=1 to addr 3 during clear -> clear restarts and busy lasts a further DATA_DEPTH cycles; addr 3 reads 0.
6. With PARITY_EN defined: force a bit flip in the stored byte 2 of addr 7, then read it -> parity_err=1 with read_valid; a clean address gives parity_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port memory bank.
// Covers read latency selection, clear FSM states, byte merge and parity.
package mem_pkg;

  typedef enum logic {
    LAT1,
    LAT2
  } read_latency_e;

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_b,
    input logic [7:0] nw_b,
    input logic       strb
  );
    return strb ? nw_b : old_b;
  endfunction

  function automatic logic even_parity(
    input logic [7:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every address writing zero,
// holding busy high until the last word is written.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam clr_state_e RST_ST = CLEAR_ON_RESET ? CLEAR : READY;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    r_state;
  clr_state_e    w_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_ST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    unique case (r_state)
      CLEAR: begin
        busy      = 1'b1;
        clr_we    = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == LAST) w_next = READY;
      end
      READY: ;
      default: ;
    endcase
  end

  assign clr_addr = r_cnt;

endmodule

// File: rtl/dual_port_memory_bank_wide.sv
// Simple dual-port RAM bank with byte strobes, write-first forwarding,
// post-reset clear and 1/2-cycle read latency. Option: DUAL_PORT_MEMORY_BANK_PARITY_EN.
module dual_port_memory_bank_wide
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_DEPTH     = 4096,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NB            = DATA_WIDTH / 8,
  localparam int AW            = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  input  logic                  we,
  input  logic [NB-1:0]         wstrb,
  input  logic [AW-1:0]         addr_a,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  re,
  input  logic [AW-1:0]         addr_b,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam read_latency_e LAT = (READ_LATENCY == 2) ? LAT2 : LAT1;

`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
  localparam int PW = DATA_WIDTH + 1;
`else
  localparam int PW = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic                  w_clr_we;
  logic [AW-1:0]         w_clr_addr;
  logic                  w_wr;
  logic                  w_re;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [PW-1:0]         w_pkt;
  logic [PW-1:0]         r_pkt;
  logic                  r_valid;

  mem_clear_seq #(
    .DEPTH          (DATA_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr  = we & ~busy;
  assign w_re  = re & ~busy;
  assign w_fwd = w_wr & (addr_a == addr_b);

  // Clear owns the write port while it runs; user writes are dropped.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) r_mem[addr_a][8*i +: 8] <= write_data[8*i +: 8];
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NB; i++)
      w_rd_word[8*i +: 8] = byte_merge(r_mem[addr_b][8*i +: 8],
                                       write_data[8*i +: 8],
                                       w_fwd & wstrb[i]);
  end

`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
  logic [NB-1:0] r_par [DATA_DEPTH];
  logic [NB-1:0] w_par_rd;
  logic [NB-1:0] w_par_calc;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[w_clr_addr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) r_par[addr_a][i] <= even_parity(write_data[8*i +: 8]);
    end
  end

  always_comb begin
    w_par_rd   = '0;
    w_par_calc = '0;
    for (int i = 0; i < NB; i++) begin
      w_par_rd[i] = (w_fwd & wstrb[i]) ? even_parity(write_data[8*i +: 8])
                                       : r_par[addr_b][i];
      w_par_calc[i] = even_parity(w_rd_word[8*i +: 8]);
    end
  end

  assign w_pkt      = {|(w_par_rd ^ w_par_calc), w_rd_word};
  assign parity_err = r_pkt[DATA_WIDTH] & r_valid;
`else
  assign w_pkt = w_rd_word;
`endif

  generate
    if (LAT == LAT2) begin : g_lat2
      logic          r_s1_valid;
      logic [PW-1:0] r_s1_pkt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_pkt   <= '0;
          r_valid    <= 1'b0;
          r_pkt      <= '0;
        end else begin
          r_s1_valid <= w_re;
          if (w_re) r_s1_pkt <= w_pkt;
          r_valid <= r_s1_valid;
          if (r_s1_valid) r_pkt <= r_s1_pkt;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_pkt   <= '0;
        end else begin
          r_valid <= w_re;
          if (w_re) r_pkt <= w_pkt;
        end
      end
    end
  endgenerate

  assign read_data  = r_pkt[DATA_WIDTH-1:0];
  assign read_valid = r_valid;

endmodule

// File: tb/tb_dual_port_memory_bank_wide.sv
// Scoreboard bench driving a latency-1 and a latency-2 bank in lockstep.
// Parity checks are built when DUAL_PORT_MEMORY_BANK_PARITY_EN is defined.
module tb_dual_port_memory_bank_wide;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [3:0]  wstrb;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] wdata;
  logic        busy1, busy2, rv1, rv2;
  logic [31:0] rd1, rd2;
  logic        pe1 = 1'b0;
  logic        pe2 = 1'b0;

  always #5 clk = ~clk;

  dual_port_memory_bank_wide #(
    .DATA_WIDTH(32), .DATA_DEPTH(D), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .busy(busy1), .we(we), .wstrb(wstrb),
    .addr_a(addr_a), .write_data(wdata), .re(re), .addr_b(addr_b),
    .read_data(rd1), .read_valid(rv1)
`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
    , .parity_err(pe1)
`endif
  );

  dual_port_memory_bank_wide #(
    .DATA_WIDTH(32), .DATA_DEPTH(D), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .busy(busy2), .we(we), .wstrb(wstrb),
    .addr_a(addr_a), .write_data(wdata), .re(re), .addr_b(addr_b),
    .read_data(rd2), .read_valid(rv2)
`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
    , .parity_err(pe2)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        pe;
    int          due;
  } exp_t;

  exp_t        q[2][$];
  logic [31:0] last[2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic mon(input int k, input logic rv, input logic [31:0] rd,
                     input logic pe);
    exp_t e;
    if (!rst_n) begin
      check($sformatf("rst_valid%0d", k), {31'b0, rv}, 32'd0);
      check($sformatf("rst_data%0d", k), rd, 32'd0);
      last[k] = '0;
    end else if (rv) begin
      if (q[k].size() == 0) begin
        check($sformatf("unexpected_valid%0d", k), 32'd1, 32'd0);
      end else begin
        e = q[k].pop_front();
        check($sformatf("rdata%0d", k), rd, e.d);
        check($sformatf("latency%0d", k), cyc, e.due);
`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
        check($sformatf("perr%0d", k), {31'b0, pe}, {31'b0, e.pe});
`endif
        last[k] = e.d;
      end
    end else begin
      check($sformatf("hold%0d", k), rd, last[k]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv1, rd1, pe1);
    mon(1, rv2, rd2, pe2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic pe);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.due = cyc + 1;
    q[0].push_back(e);
    e.due = cyc + 2;
    q[1].push_back(e);
  endtask

  task automatic drive(input logic w, input logic [3:0] s,
                       input logic [3:0] aa, input logic [31:0] d,
                       input logic r, input logic [3:0] ab);
    we = w;
    wstrb = s;
    addr_a = aa;
    wdata = d;
    re = r;
    addr_b = ab;
  endtask

  task automatic drain();
    int t = 0;
    we = 1'b0;
    re = 1'b0;
    while ((q[0].size() + q[1].size()) != 0 && t < 20) begin
      tick();
      t++;
    end
    check("drain", q[0].size() + q[1].size(), 32'd0);
    tick();
  endtask

  task automatic wait_clear();
    int n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick();
    end
    check("busy_cycles", n, D);
    check("busy2_done", {31'b0, busy2}, 32'd0);
  endtask

  initial begin
    drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("busy_in_reset", {31'b0, busy1}, 32'd1);
    rst_n = 1'b1;
    wait_clear();

    for (int a = 0; a < D; a++) begin
      drive(0, 4'h0, 4'h0, 32'h0, 1, 4'(a));
      push(32'h0, 1'b0);
      tick();
    end
    drain();

    drive(1, 4'hF, 4'd5, 32'hDEADBEEF, 0, 4'd0); tick();
    drive(1, 4'h1, 4'd5, 32'h000000AA, 0, 4'd0); tick();
    drive(1, 4'h0, 4'd5, 32'hFFFFFFFF, 0, 4'd0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd5);
    push(32'hDEADBEAA, 1'b0);
    tick();
    drain();

    drive(1, 4'hF, 4'd9, 32'hAABBCCDD, 0, 4'd0); tick();
    drive(1, 4'h6, 4'd9, 32'h11223344, 1, 4'd9);
    push(32'hAA2233DD, 1'b0);
    tick();
    drive(1, 4'hF, 4'd10, 32'h55555555, 1, 4'd9);
    push(32'hAA2233DD, 1'b0);
    tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd10);
    push(32'h55555555, 1'b0);
    tick();
    drain();

    drive(1, 4'hF, 4'd1, 32'h11111111, 0, 4'd0); tick();
    drive(1, 4'hF, 4'd2, 32'h22222222, 0, 4'd0); tick();
    drive(1, 4'hF, 4'd3, 32'h33333333, 0, 4'd0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd1); push(32'h11111111, 1'b0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd2); push(32'h22222222, 1'b0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd3); push(32'h33333333, 1'b0); tick();
    drain();
    repeat (3) tick();

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    drive(1, 4'hF, 4'd3, 32'hFFFFFFFF, 1, 4'd3);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd3); push(32'h0, 1'b0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd1); push(32'h0, 1'b0); tick();
    drain();

`ifdef DUAL_PORT_MEMORY_BANK_PARITY_EN
    drive(1, 4'hF, 4'd7, 32'h12345678, 0, 4'd0); tick();
    drive(1, 4'hF, 4'd5, 32'hDEADBEAA, 0, 4'd0); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 0, 4'd0); tick();
    u1.r_mem[7][16] = ~u1.r_mem[7][16];
    u2.r_mem[7][16] = ~u2.r_mem[7][16];
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd7); push(32'h12355678, 1'b1); tick();
    drive(0, 4'h0, 4'd0, 32'h0, 1, 4'd5); push(32'hDEADBEAA, 1'b0); tick();
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
